// File: rtl/mem_access_unit_pkg.sv
// Shared types for the MEM-stage data-memory access unit: op codes, FSM states and
// request decode helpers.
package mem_access_unit_pkg;

  localparam int unsigned DmAddrWDefault = 14;

  typedef enum logic [2:0] {
    OpLw  = 3'd0,
    OpLh  = 3'd1,
    OpLhu = 3'd2,
    OpLb  = 3'd3,
    OpLbu = 3'd4,
    OpSw  = 3'd5,
    OpSh  = 3'd6,
    OpSb  = 3'd7
  } mem_op_e;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StLoad  = 3'd1,
    StRmwRd = 3'd2,
    StStore = 3'd3,
    StResp  = 3'd4
  } mau_state_e;

  function automatic logic is_load(input mem_op_e op);
    return (op <= OpLbu);
  endfunction

  function automatic logic is_misaligned(input mem_op_e op, input logic [1:0] addr_lo);
    logic w_bad;
    case (op)
      OpLw, OpSw:       w_bad = (addr_lo != 2'b00);
      OpLh, OpLhu, OpSh: w_bad = addr_lo[0];
      default:          w_bad = 1'b0;
    endcase
    return w_bad;
  endfunction

endpackage

// File: rtl/mem_access_unit_lsu_lane_mux.sv
// Byte/half lane handling for the word-only DM: load extract+extend and store merge.
module mem_access_unit_lsu_lane_mux
  import mem_access_unit_pkg::*;
(
  input  mem_op_e     i_op,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_dout,
  input  logic [31:0] i_merge,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_load_data,
  output logic [31:0] o_store_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_dout[7:0];
    case (i_addr_lo)
      2'd1:    w_byte = i_dout[15:8];
      2'd2:    w_byte = i_dout[23:16];
      2'd3:    w_byte = i_dout[31:24];
      default: w_byte = i_dout[7:0];
    endcase
    w_half = i_addr_lo[1] ? i_dout[31:16] : i_dout[15:0];

    o_load_data = i_dout;
    case (i_op)
      OpLb:    o_load_data = {{24{w_byte[7]}}, w_byte};
      OpLbu:   o_load_data = {24'h0, w_byte};
      OpLh:    o_load_data = {{16{w_half[15]}}, w_half};
      OpLhu:   o_load_data = {16'h0, w_half};
      default: o_load_data = i_dout;
    endcase
  end

  always_comb begin
    o_store_data = i_wdata;
    case (i_op)
      OpSh: begin
        o_store_data = i_merge;
        if (i_addr_lo[1]) o_store_data[31:16] = i_wdata[15:0];
        else              o_store_data[15:0]  = i_wdata[15:0];
      end
      OpSb: begin
        o_store_data = i_merge;
        case (i_addr_lo)
          2'd1:    o_store_data[15:8]  = i_wdata[7:0];
          2'd2:    o_store_data[23:16] = i_wdata[7:0];
          2'd3:    o_store_data[31:24] = i_wdata[7:0];
          default: o_store_data[7:0]   = i_wdata[7:0];
        endcase
      end
      default: o_store_data = i_wdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage initiator for the word-only data memory: one request per handshake,
// sub-word stores via read-modify-write, response on a valid/ready channel.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int unsigned DM_ADDR_W = DmAddrWDefault
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic [2:0]  i_req_op,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  input  logic [31:0] i_req_pc,
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic [31:0] o_rsp_rdata,
  output logic        o_rsp_err,
  output logic        o_dm_we,
  output logic [31:0] o_dm_addr,
  output logic [31:0] o_dm_din,
  output logic [31:0] o_dm_pc,
  input  logic [31:0] i_dm_dout
);

  mau_state_e  r_state, w_state_nxt;
  mem_op_e     r_op;
  logic [31:0] r_addr, r_wdata, r_pc, r_merge, r_rdata;
  logic        r_err;

  mem_op_e     w_req_op;
  logic        w_accept, w_req_err;
  logic [31:0] w_load_data, w_store_data;

  assign w_req_op  = mem_op_e'(i_req_op);
  assign w_accept  = i_req_valid && (r_state == StIdle);
  assign w_req_err = is_misaligned(w_req_op, i_req_addr[1:0]) | (|i_req_addr[31:DM_ADDR_W]);

  mem_access_unit_lsu_lane_mux u_lane_mux (
    .i_op        (r_op),
    .i_addr_lo   (r_addr[1:0]),
    .i_dout      (i_dm_dout),
    .i_merge     (r_merge),
    .i_wdata     (r_wdata),
    .o_load_data (w_load_data),
    .o_store_data(w_store_data)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= StIdle;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle: begin
        if (w_accept) begin
          if (w_req_err)              w_state_nxt = StResp;
          else if (is_load(w_req_op)) w_state_nxt = StLoad;
          else if (w_req_op == OpSw)  w_state_nxt = StStore;
          else                        w_state_nxt = StRmwRd;
        end
      end
      StLoad:  w_state_nxt = StResp;
      StRmwRd: w_state_nxt = StStore;
      StStore: w_state_nxt = StResp;
      StResp:  if (i_rsp_ready) w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  // Request latches; rdata is cleared on accept so stores/errors return zero.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_op    <= OpLw;
      r_addr  <= '0;
      r_wdata <= '0;
      r_pc    <= '0;
      r_merge <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_op    <= w_req_op;
        r_addr  <= i_req_addr;
        r_wdata <= i_req_wdata;
        r_pc    <= i_req_pc;
        r_err   <= w_req_err;
        r_rdata <= '0;
      end
      if (r_state == StLoad)  r_rdata <= w_load_data;
      if (r_state == StRmwRd) r_merge <= i_dm_dout;
    end
  end

  always_comb begin
    o_req_ready = (r_state == StIdle);
    o_rsp_valid = (r_state == StResp);
    o_dm_we     = (r_state == StStore);
    o_dm_din    = (r_state == StStore) ? w_store_data : '0;
    o_dm_addr   = {r_addr[31:2], 2'b00};
    o_dm_pc     = r_pc;
    o_rsp_rdata = r_rdata;
    o_rsp_err   = r_err;
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a behavioural word-wide data memory.
module tb_mem_access_unit;

  localparam logic [2:0] LW = 3'd0, LH = 3'd1, LHU = 3'd2, LB = 3'd3, LBU = 3'd4;
  localparam logic [2:0] SW = 3'd5, SH = 3'd6, SB = 3'd7;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, rsp_valid, rsp_ready, rsp_err, dm_we;
  logic [2:0]  req_op;
  logic [31:0] req_addr, req_wdata, req_pc, rsp_rdata, dm_addr, dm_din, dm_pc, dm_dout;

  logic [31:0] mem [0:4095];
  logic        pl_en;
  logic [11:0] pl_idx;
  logic [31:0] pl_data;

  int n_checks = 0;
  int n_errors = 0;
  int lat, we_cnt;
  logic [31:0] din_seen, addr_seen;

  always #5 clk = ~clk;

  mem_access_unit #(.DM_ADDR_W(14)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_req_valid(req_valid),
    .o_req_ready(req_ready),
    .i_req_op   (req_op),
    .i_req_addr (req_addr),
    .i_req_wdata(req_wdata),
    .i_req_pc   (req_pc),
    .o_rsp_valid(rsp_valid),
    .i_rsp_ready(rsp_ready),
    .o_rsp_rdata(rsp_rdata),
    .o_rsp_err  (rsp_err),
    .o_dm_we    (dm_we),
    .o_dm_addr  (dm_addr),
    .o_dm_din   (dm_din),
    .o_dm_pc    (dm_pc),
    .i_dm_dout  (dm_dout)
  );

  assign dm_dout = mem[dm_addr[13:2]];

  always @(posedge clk) begin
    if (dm_we)      mem[dm_addr[13:2]] <= dm_din;
    else if (pl_en) mem[pl_idx] <= pl_data;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [31:0] byte_addr, input logic [31:0] data);
    pl_en   = 1'b1;
    pl_idx  = byte_addr[13:2];
    pl_data = data;
    tick();
    pl_en   = 1'b0;
  endtask

  // Accept one request, then count cycles until rsp_valid, recording any DM writes.
  task automatic issue(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] pc);
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = addr;
    req_wdata = wdata;
    req_pc    = pc;
    tick();
    req_valid = 1'b0;
    lat       = 1;
    we_cnt    = 0;
    din_seen  = '0;
    addr_seen = '0;
    while (!rsp_valid && lat < 10) begin
      if (dm_we) begin
        we_cnt++;
        din_seen  = dm_din;
        addr_seen = dm_addr;
      end
      tick();
      lat++;
    end
  endtask

  task automatic respond(input string tag);
    chk({tag, "_rsp_valid"}, {31'h0, rsp_valid}, 32'h1);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk({tag, "_idle_ready"}, {31'h0, req_ready}, 32'h1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0; req_op = 3'd0;
    req_addr = '0; req_wdata = '0; req_pc = '0;
    pl_en = 1'b0; pl_idx = '0; pl_data = '0;
    #12;
    chk("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    chk("rst_dm_we", {31'h0, dm_we}, 32'h0);
    chk("rst_rsp_err", {31'h0, rsp_err}, 32'h0);
    chk("rst_rdata", rsp_rdata, 32'h0);
    chk("rst_dm_addr", dm_addr, 32'h0);
    chk("rst_dm_din", dm_din, 32'h0);
    chk("rst_dm_pc", dm_pc, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("rst_req_ready", {31'h0, req_ready}, 32'h1);

    preload(32'h30, 32'h5566_7788);
    preload(32'h20, 32'h8000_F0FF);

    // SW word store
    issue(SW, 32'h10, 32'hDEAD_BEEF, 32'h100);
    chk("sw_lat", 32'(lat), 32'd2);
    chk("sw_we_cnt", 32'(we_cnt), 32'd1);
    chk("sw_din", din_seen, 32'hDEAD_BEEF);
    chk("sw_addr", addr_seen, 32'h10);
    chk("sw_err", {31'h0, rsp_err}, 32'h0);
    chk("sw_rdata", rsp_rdata, 32'h0);
    chk("sw_pc", dm_pc, 32'h100);
    respond("sw");
    chk("sw_mem", mem[4], 32'hDEAD_BEEF);

    // SB / SH read-modify-write; upper wdata bits must be ignored
    preload(32'h10, 32'h1122_3344);
    issue(SB, 32'h12, 32'h1234_56AA, 32'h104);
    chk("sb_lat", 32'(lat), 32'd3);
    chk("sb_we_cnt", 32'(we_cnt), 32'd1);
    chk("sb_din", din_seen, 32'h11AA_3344);
    chk("sb_addr", addr_seen, 32'h10);
    respond("sb");
    chk("sb_mem", mem[4], 32'h11AA_3344);

    issue(SH, 32'h12, 32'hFFFF_BEEF, 32'h108);
    chk("sh_lat", 32'(lat), 32'd3);
    chk("sh_din", din_seen, 32'hBEEF_3344);
    respond("sh");

    // Loads from word 0x20 = 0x8000F0FF
    issue(LB, 32'h20, 32'h0, 32'h10C);
    chk("lb_lat", 32'(lat), 32'd2);
    chk("lb_we_cnt", 32'(we_cnt), 32'd0);
    chk("lb_rdata", rsp_rdata, 32'hFFFF_FFFF);
    chk("lb_err", {31'h0, rsp_err}, 32'h0);
    respond("lb");
    issue(LBU, 32'h21, 32'h0, 32'h110);
    chk("lbu_rdata", rsp_rdata, 32'h0000_00F0);
    respond("lbu");
    issue(LH, 32'h22, 32'h0, 32'h114);
    chk("lh_rdata", rsp_rdata, 32'hFFFF_8000);
    respond("lh");
    issue(LHU, 32'h22, 32'h0, 32'h118);
    chk("lhu_rdata", rsp_rdata, 32'h0000_8000);
    respond("lhu");
    issue(LW, 32'h20, 32'h0, 32'h11C);
    chk("lw_rdata", rsp_rdata, 32'h8000_F0FF);
    respond("lw");

    // Errors: misaligned and out of range
    issue(LW, 32'h6, 32'h0, 32'h120);
    chk("lw_mis_lat", 32'(lat), 32'd1);
    chk("lw_mis_err", {31'h0, rsp_err}, 32'h1);
    chk("lw_mis_we", 32'(we_cnt), 32'd0);
    chk("lw_mis_rdata", rsp_rdata, 32'h0);
    respond("lw_mis");
    issue(SW, 32'h4000, 32'h1234_5678, 32'h124);
    chk("sw_oor_lat", 32'(lat), 32'd1);
    chk("sw_oor_err", {31'h0, rsp_err}, 32'h1);
    chk("sw_oor_we", 32'(we_cnt), 32'd0);
    respond("sw_oor");
    issue(LH, 32'h21, 32'h0, 32'h128);
    chk("lh_mis_err", {31'h0, rsp_err}, 32'h1);
    respond("lh_mis");

    // Backpressure: response held, no new request accepted
    issue(LW, 32'h20, 32'h0, 32'h12C);
    req_valid = 1'b1; req_op = SW; req_addr = 32'h40; req_wdata = 32'hCAFE_F00D;
    for (int i = 0; i < 5; i++) begin
      chk("hold_valid", {31'h0, rsp_valid}, 32'h1);
      chk("hold_rdata", rsp_rdata, 32'h8000_F0FF);
      chk("hold_ready", {31'h0, req_ready}, 32'h0);
      chk("hold_we", {31'h0, dm_we}, 32'h0);
      tick();
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("hold_release_ready", {31'h0, req_ready}, 32'h1);
    chk("hold_release_valid", {31'h0, rsp_valid}, 32'h0);

    // Reset asserted while SB sits in STORE
    req_valid = 1'b1; req_op = SB; req_addr = 32'h31; req_wdata = 32'h0000_00CC;
    tick();
    req_valid = 1'b0;
    chk("rst_sb_rmw_we", {31'h0, dm_we}, 32'h0);
    tick();
    chk("rst_sb_store_we", {31'h0, dm_we}, 32'h1);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_sb_we_drop", {31'h0, dm_we}, 32'h0);
    chk("rst_sb_addr", dm_addr, 32'h0);
    chk("rst_sb_din", dm_din, 32'h0);
    chk("rst_sb_valid", {31'h0, rsp_valid}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("rst_sb_ready", {31'h0, req_ready}, 32'h1);
    chk("rst_sb_mem", mem[12], 32'h5566_7788);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
